key_event: RTL and testbench

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_pkg.sv | 19 +
 rtl/key_fifo.sv | 59 +++++
 rtl/key_event.sv | 169 ++++++++++++++++
 tb/tb_key_event.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key event block: FSM state encoding,
// the scanner's "no key" code, key code width and a saturating increment.
package key_pkg;

    localparam int         KEY_W  = 4;
    localparam logic [4:0] NO_KEY = 5'h1F;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } key_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous event queue. A push while full is only accepted when a
// pop happens in the same cycle; otherwise it is dropped and the contents
// stay as they were. The head reads as zero while the queue is empty.
module key_fifo
    import key_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = KEY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event.sv
// Debounces scanned key codes into press events queued for a consumer.
// Optional auto-repeat while a key is held is built only when the macro
// KEY_REPEAT_EN is defined.
//
// state    | meaning
// IDLE     | no key seen, waiting for a scanner code
// DEBOUNCE | candidate code must persist DEB_CYCLES before acceptance
// HELD     | key accepted, key_down asserted
// RELEASE  | no-key run in progress; REL_CYCLES of it ends the press
module key_event
    import key_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES   = 16'd2000,
    parameter logic [15:0] REL_CYCLES   = 16'd256,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [23:0] REPEAT_DELAY = 24'd500000,
    parameter logic [23:0] REPEAT_RATE  = 24'd100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       key_val,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_down,
    output logic             overflow,
    input  logic             clr_ovf
);

    key_state_t       state;
    logic [KEY_W-1:0] cand;
    logic [15:0]      deb_cnt;
    logic [15:0]      gap_cnt;
    logic [15:0]      gap_inc;
    logic             no_key;
    logic             same_key;
    logic             gap_done;
    logic             deb_done;
    logic             deb_push;
    logic             rep_push;
    logic             push;
    logic             full;
    logic             empty;
    logic             drop;

    assign no_key   = (key_val == NO_KEY);
    assign same_key = (key_val == {1'b0, cand});
    assign gap_inc  = sat_inc16(gap_cnt);
    assign gap_done = no_key && (gap_inc >= REL_CYCLES);
    assign deb_done = (deb_cnt >= (DEB_CYCLES - 16'd1));
    assign deb_push = (state == DEBOUNCE) && (no_key || same_key) && !gap_done && deb_done;
    assign push     = deb_push || rep_push;
    assign drop     = push && full && !(key_valid && key_ready);

    // Press/release sequencing; key_down is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cand     <= '0;
            deb_cnt  <= '0;
            gap_cnt  <= '0;
            key_down <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!no_key) begin
                        state   <= DEBOUNCE;
                        cand    <= key_val[KEY_W-1:0];
                        deb_cnt <= '0;
                        gap_cnt <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (!no_key && !same_key) begin
                        cand    <= key_val[KEY_W-1:0];
                        deb_cnt <= '0;
                        gap_cnt <= '0;
                    end else if (gap_done) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                        gap_cnt <= '0;
                    end else if (deb_done) begin
                        state    <= HELD;
                        key_down <= 1'b1;
                        deb_cnt  <= '0;
                        gap_cnt  <= '0;
                    end else begin
                        deb_cnt <= sat_inc16(deb_cnt);
                        gap_cnt <= no_key ? gap_inc : '0;
                    end
                end
                HELD: begin
                    // Other codes are ignored: no rollover to a second key.
                    if (no_key) begin
                        state   <= RELEASE;
                        gap_cnt <= 16'd1;
                    end
                end
                RELEASE: begin
                    if (same_key) begin
                        state   <= HELD;
                        gap_cnt <= '0;
                    end else if (gap_done) begin
                        state    <= IDLE;
                        key_down <= 1'b0;
                        gap_cnt  <= '0;
                    end else if (no_key) begin
                        gap_cnt <= gap_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    logic [23:0] rep_cnt;

    assign rep_push = ((state == HELD) || (state == RELEASE)) &&
                      (rep_cnt == REPEAT_DELAY - 24'd1);

    // Repeat timer: first repeat after REPEAT_DELAY, then rewound so the
    // next hit lands REPEAT_RATE cycles later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else if ((state == IDLE) || (state == DEBOUNCE)) begin
            rep_cnt <= '0;
        end else if (rep_push) begin
            rep_cnt <= REPEAT_DELAY - REPEAT_RATE;
        end else if (rep_cnt != 24'hFFFFFF) begin
            rep_cnt <= rep_cnt + 24'd1;
        end
    end
`else
    logic unused_rep;

    assign rep_push   = 1'b0;
    assign unused_rep = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

    // Sticky overflow; a drop outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KEY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (key_ready),
        .din   (cand),
        .dout  (key_code),
        .full  (full),
        .empty (empty)
    );

    assign key_valid = !empty;

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event with DEB_CYCLES=8, REL_CYCLES=4, FIFO_DEPTH=4.
// Expected events go into a scoreboard queue when a press is issued; a
// negedge monitor pops and compares whenever the DUT hands over an event.
module tb_key_event;

    localparam int DEB   = 8;
    localparam int REL   = 4;
    localparam int DEPTH = 4;
    localparam int RDLY  = 20;
    localparam int RRATE = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] key_val = 5'h1F;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       key_down;
    logic       overflow;
    logic       clr_ovf = 1'b0;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] sb[$];
    logic [3:0] mon_exp;
    bit         rnd_ready = 1'b0;

    key_event #(
        .DEB_CYCLES   (16'(DEB)),
        .REL_CYCLES   (16'(REL)),
        .FIFO_DEPTH   (DEPTH),
        .REPEAT_DELAY (24'(RDLY)),
        .REPEAT_RATE  (24'(RRATE))
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_val   (key_val),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_down  (key_down),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    // Monitor: every handed-over event must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && key_valid && key_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got code %0d, expected no event", key_code);
            end else begin
                mon_exp = sb.pop_front();
                if (key_code !== mon_exp) begin
                    n_fail++;
                    $display("FAIL event_code: got %0d, expected %0d", key_code, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] v, input int n);
        repeat (n) begin
            key_val = v;
            if (rnd_ready) key_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int c = 0;
        key_ready = 1'b1;
        while (sb.size() > 0 && c < 60) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic pulse_clr();
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
    endtask

    initial begin
        int occ;
        int n_rep;
        logic [3:0] k;
        int len;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_down", key_down, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;

        // Single press: accepted on the ninth cycle of a steady code
        drive(5'd5, DEB);
        check("press_early_valid", key_valid, 0);
        drive(5'd5, 1);
        sb.push_back(4'd5);
        check("press_valid", key_valid, 1);
        check("press_code", key_code, 5);
        check("press_down", key_down, 1);
        drive(5'd5, 1);
        drive(5'h1F, REL - 1);
        check("release_window_down", key_down, 1);
        drive(5'h1F, 1);
        check("release_down", key_down, 0);
        drain("drain_single");

        // Short glitch: no event, back to idle (fresh debounce afterwards)
        drive(5'd5, 3);
        drive(5'h1F, REL);
        check("glitch_valid", key_valid, 0);
        check("glitch_down", key_down, 0);
        key_ready = 1'b0;
        drive(5'd5, DEB);
        check("glitch_idle_valid", key_valid, 0);
        drive(5'd5, 1);
        sb.push_back(4'd5);
        check("after_glitch_valid", key_valid, 1);
        drive(5'h1F, REL + 2);
        drain("drain_glitch");

        // Column scan pattern: one event, release after the window
        sb.push_back(4'd5);
        repeat (10) begin
            drive(5'd5, 1);
            drive(5'h1F, 3);
        end
        check("scan_down_held", key_down, 1);
        drive(5'h1F, 1);
        check("scan_down_released", key_down, 0);
        drive(5'h1F, 3);
        drain("drain_scan");

        // Random presses with random back-pressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            k = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) begin
                len = $urandom_range(DEB + 1, DEB + 7);
                sb.push_back(k);
            end else begin
                len = $urandom_range(1, 3);
            end
            drive({1'b0, k}, len);
            drive(5'h1F, $urandom_range(REL + 2, REL + 5));
        end
        rnd_ready = 1'b0;
        drain("drain_random");
        check("random_ovf", overflow, 0);

        // Overflow: five presses with nobody consuming
        key_ready = 1'b0;
        occ = 0;
        for (int i = 1; i <= 5; i++) begin
            if (occ < DEPTH) begin
                sb.push_back(4'(i));
                occ++;
            end
            drive(5'(i), DEB + 1);
            drive(5'h1F, REL + 1);
        end
        check("full_ovf", overflow, 1);
        check("full_head", key_code, 1);
        pulse_clr();
        check("clr_ovf", overflow, 0);
        // Drop coinciding with a clear: the drop wins
        clr_ovf = 1'b1;
        drive(5'd7, DEB + 1);
        clr_ovf = 1'b0;
        check("drop_beats_clr", overflow, 1);
        drive(5'h1F, REL + 1);
        pulse_clr();
        // Press accepted in the same cycle as a pop while full
        drive(5'd6, DEB);
        key_ready = 1'b1;
        drive(5'd6, 1);
        key_ready = 1'b0;
        sb.push_back(4'd6);
        check("push_pop_full_ovf", overflow, 0);
        check("push_pop_full_valid", key_valid, 1);
        drive(5'h1F, REL + 1);
        drain("drain_overflow");

        // Held key: auto-repeat only when built in
        n_rep = 1;
`ifdef KEY_REPEAT_EN
        if (45 >= RDLY) n_rep = 2 + (45 - RDLY) / RRATE;
`endif
        for (int i = 0; i < n_rep; i++) sb.push_back(4'd7);
        key_ready = 1'b1;
        drive(5'd7, DEB + 1);
        drive(5'd7, 45);
        drive(5'h1F, REL + 2);
        drain("drain_repeat");

        // Reset while held with two queued events
        key_ready = 1'b0;
        drive(5'd3, DEB + 1);
        drive(5'h1F, REL + 1);
        drive(5'd9, DEB + 1);
        check("pre_reset_down", key_down, 1);
        rst_n = 1'b0;
        drive(5'd9, 1);
        rst_n = 1'b1;
        check("reset_valid", key_valid, 0);
        check("reset_down", key_down, 0);
        drive(5'd9, DEB);
        check("post_reset_early", key_valid, 0);
        drive(5'd9, 1);
        sb.push_back(4'd9);
        check("post_reset_valid", key_valid, 1);
        check("post_reset_code", key_code, 9);
        check("post_reset_down", key_down, 1);
        drive(5'h1F, REL + 1);
        drain("drain_reset");
        check("final_empty_code", key_code, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
